sdram_chan_arbiter: RTL and testbench
=====================================

Name: sdram_chan_arbiter

Overview:
- Shares one edge-triggered channel of the 3-channel SDRAM controller (addrN/rdN/wrlN/wrhN/dinN/doutN/busyN) between N clients.
- Each client uses a level req/ack handshake. Arbitration is round-robin or fixed-priority.
- The block generates the rising-edge strobe the controller needs, tracks busy to detect completion, and returns read data with a one-cycle ack.
- Typical use: CD-ROM buffer, PCM/wave RAM and sub-CPU word-RAM traffic sharing the second SDRAM channel.

Parameters:
- N, 4, number of clients (2..8).
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
- WD_CYCLES, 31, issue watchdog: cycles in ISSUE without busy=1 before a strobe is retried (must be >= 8).

Ports:
- clk  in  1  memory clock, same as the SDRAM controller clock.
- reset  in  1  synchronous, active-high.
- cli_req  in  N  per-client request level; held until the matching ack.
- cli_we  in  N  1 = write, 0 = read; stable while req is high.
- cli_be  in  2N  byte enables {hi,lo} per client, used for writes only.
- cli_addr  in  24N  word address [24:1] per client.
- cli_din  in  16N  write data per client.
- cli_ack  out  N  one-cycle completion pulse, one-hot.
- cli_dout  out  16  read data, valid in the cycle of a read ack; shared by all clients.
- mem_addr  out  24  to controller addrX.
- mem_rd  out  1  to controller rdX.
- mem_wrl  out  1  to controller wrlX.
- mem_wrh  out  1  to controller wrhX.
- mem_din  out  16  to controller dinX.
- mem_dout  in  16  from controller doutX.
- mem_busy  in  1  from controller busyX.

Behaviour:
- All outputs are registered.
- Reset values: cli_ack=0, cli_dout=0, mem_rd=mem_wrl=mem_wrh=0, mem_addr=0, mem_din=0, rr pointer=N-1, state=SYNC.

State machine:
- SYNC: wait until mem_busy=0, then go to IDLE. Covers reset arriving mid-transaction; any result from that transaction is discarded.
- IDLE: if any cli_req is high and mem_busy=0, pick the winner:
  - round-robin: first requester at index ptr+1, ptr+2, … modulo N;
  - fixed priority: lowest index.
  - Latch the winner index, addr, din, we and be into mem_*. Set ptr = winner (round-robin only).
  - Go to ISSUE; the strobes become visible on the next cycle.
  - Write with be=00: no memory access. Pulse ack for the winner on the next cycle and return to IDLE (2 cycles total).
- ISSUE: drive mem_rd=~we, mem_wrl=we&be[0], mem_wrh=we&be[1].
  - When mem_busy=1, go to WAIT.
  - Watchdog counter increments each ISSUE cycle. On reaching WD_CYCLES, drop all strobes for exactly one cycle (GAP), clear the counter, then return to ISSUE. This forces a new rising edge.
- WAIT: keep the strobes asserted. On mem_busy=0:
  - drop all strobes;
  - register cli_dout <= mem_dout (reads only; writes leave cli_dout unchanged);
  - assert cli_ack[winner] for exactly one cycle;
  - go to IDLE.
- IDLE is entered with strobes low, so the next strobe is always preceded by at least one low cycle. The controller's edge detector therefore always re-arms.
- Back-to-back requests:
  - A client may drop req in the ack cycle or keep it high.
  - A req still high in the ack cycle is treated as a new request, eligible at the next IDLE evaluation, which is the cycle after ack.
  - Clients must change addr/din/we/be only when req is low or in the ack cycle.
- Request lifetime:
  - A req dropped before ack while the block is in ISSUE/WAIT does not abort the transaction. It completes and the ack is still pulsed; the client ignores it.
  - A req dropped while not yet granted is simply not considered.
- Simultaneous events:
  - A new req arriving in the ack cycle of another client is arbitrated in the next IDLE.
  - reset has priority over every event in the same cycle.
- Fairness: with FIXED_PRIO=0 and all N clients requesting continuously, each client is served exactly once per N grants.
- Width rules: cli_addr slice k is bits [24k+23:24k]; be slice k is [2k+1:2k]; din slice k is [16k+15:16k].
- Latency: minimum req-to-ack = 1 (IDLE) + 1 (ISSUE) + controller time until busy falls + 1.

Test Plan:
- Single read: client 2 req, we=0, addr=0x012345; model returns 0xBEEF 5 cycles after strobe → mem_rd rises 1 cycle after grant, cli_ack=4'b0100 for one cycle, cli_dout=0xBEEF.
- Byte write: client 0 we=1, be=2'b10, din=0xA55A → mem_wrh=1, mem_wrl=0, mem_din=0xA55A, then ack[0]. With be=00 → no strobe, ack 2 cycles after req.
- Round-robin: all 4 clients requesting continuously → grant order 0,1,2,3,0,1…. With FIXED_PRIO=1 → client 0 served every time while it keeps requesting.
- Strobe gap: client 1 issues 3 consecutive reads holding req high → mem_rd low for ≥1 cycle between each transaction, 3 acks, 3 distinct dout values.
- Watchdog: model ignores the first strobe (busy stays 0) → after 31 ISSUE cycles, mem_rd low 1 cycle then high again; transaction completes with ack on the retry.
- Reset mid-WAIT: assert reset while busy=1 → strobes 0 next cycle, no ack. Block stays in SYNC until busy=0, then grants a pending req normally.

Source files
------------

// File: rtl/sdram_chan_arbiter.sv
// sdram_chan_arbiter: shares one edge-triggered SDRAM controller channel
// between N level req/ack clients. Supports round-robin or fixed priority.
// Every strobe rises from a low cycle, so the controller's edge detector
// always re-arms. A watchdog re-issues a strobe that the controller missed.
module sdram_chan_arbiter #(
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0,
  parameter int WD_CYCLES  = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    cli_req,
  input  logic [N-1:0]    cli_we,
  input  logic [2*N-1:0]  cli_be,
  input  logic [24*N-1:0] cli_addr,
  input  logic [16*N-1:0] cli_din,
  output logic [N-1:0]    cli_ack,
  output logic [15:0]     cli_dout,
  output logic [23:0]     mem_addr,
  output logic            mem_rd,
  output logic            mem_wrl,
  output logic            mem_wrh,
  output logic [15:0]     mem_din,
  input  logic [15:0]     mem_dout,
  input  logic            mem_busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(WD_CYCLES + 1);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_ISSUE, S_GAP, S_WAIT} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d, win_q, win_d, arb_idx;
  logic           we_q, we_d;
  logic [1:0]     be_q, be_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [23:0]    addr_q, addr_d;
  logic [15:0]    din_q, din_d, dout_q, dout_d;
  logic           rd_q, rd_d, wrl_q, wrl_d, wrh_q, wrh_d;
  logic [N-1:0]   ack_q, ack_d;
  int             sel;

  // Winner selection: the last hit in the reversed scan is the first in priority order.
  always_comb begin
    arb_idx = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = N-1; i >= 0; i--)
        if (cli_req[i]) arb_idx = IW'(i);
    end else begin
      for (int i = N; i >= 1; i--)
        if (cli_req[(int'(ptr_q) + i) % N]) arb_idx = IW'((int'(ptr_q) + i) % N);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    be_d    = be_q;
    wd_d    = wd_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    rd_d    = rd_q;
    wrl_d   = wrl_q;
    wrh_d   = wrh_q;
    ack_d   = '0;
    sel     = int'(arb_idx);
    case (state_q)
      S_SYNC: if (!mem_busy) state_d = S_IDLE;
      S_IDLE: begin
        // No arbitration in an ack cycle: a held req becomes eligible the cycle after.
        if ((|cli_req) && !mem_busy && (ack_q == '0)) begin
          win_d  = arb_idx;
          we_d   = cli_we[sel];
          be_d   = cli_be[2*sel +: 2];
          addr_d = cli_addr[24*sel +: 24];
          din_d  = cli_din[16*sel +: 16];
          if (FIXED_PRIO == 0) ptr_d = arb_idx;
          if (cli_we[sel] && (cli_be[2*sel +: 2] == 2'b00)) begin
            // Empty write: nothing to send to memory, just acknowledge.
            ack_d[sel] = 1'b1;
          end else begin
            rd_d    = ~cli_we[sel];
            wrl_d   = cli_we[sel] & cli_be[2*sel];
            wrh_d   = cli_we[sel] & cli_be[2*sel+1];
            wd_d    = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_busy) begin
          state_d = S_WAIT;
        end else if (wd_q == WW'(WD_CYCLES - 1)) begin
          // Strobe went unnoticed: drop it for one cycle to make a fresh edge.
          rd_d    = 1'b0;
          wrl_d   = 1'b0;
          wrh_d   = 1'b0;
          wd_d    = '0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP: begin
        rd_d    = ~we_q;
        wrl_d   = we_q & be_q[0];
        wrh_d   = we_q & be_q[1];
        state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (!mem_busy) begin
          rd_d   = 1'b0;
          wrl_d  = 1'b0;
          wrh_d  = 1'b0;
          if (!we_q) dout_d = mem_dout;
          ack_d[win_q] = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  // State and output registers; reset overrides everything in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SYNC;
      ptr_q   <= IW'(N - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      wd_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      rd_q    <= 1'b0;
      wrl_q   <= 1'b0;
      wrh_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      wrl_q   <= wrl_d;
      wrh_q   <= wrh_d;
      ack_q   <= ack_d;
    end
  end

  assign cli_ack  = ack_q;
  assign cli_dout = dout_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_rd   = rd_q;
  assign mem_wrl  = wrl_q;
  assign mem_wrh  = wrh_q;
endmodule

// File: tb/tb_sdram_chan_arbiter.sv
// Directed bench for sdram_chan_arbiter: instance 0 is round-robin, and
// instance 1 is fixed priority. Each instance has a small edge-triggered
// controller model that returns read data = addr[15:0] ^ 16'h9DAA.
module tb_sdram_chan_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_fp, we;
  logic [2*N-1:0]  be;
  logic [24*N-1:0] addr;
  logic [16*N-1:0] din;

  logic [N-1:0]  ack   [2];
  logic [15:0]   cdout [2];
  logic [23:0]   maddr [2];
  logic          mrd   [2];
  logic          mwrl  [2];
  logic          mwrh  [2];
  logic [15:0]   mdin  [2];
  logic [15:0]   mdout [2];
  logic          busy  [2];

  int tests = 0;
  int fails = 0;
  int lat = 5;
  int ignore_idx = -1;

  sdram_chan_arbiter #(.N(N), .FIXED_PRIO(0), .WD_CYCLES(31)) dut (
    .clk(clk), .reset(reset), .cli_req(req), .cli_we(we), .cli_be(be),
    .cli_addr(addr), .cli_din(din), .cli_ack(ack[0]), .cli_dout(cdout[0]),
    .mem_addr(maddr[0]), .mem_rd(mrd[0]), .mem_wrl(mwrl[0]), .mem_wrh(mwrh[0]),
    .mem_din(mdin[0]), .mem_dout(mdout[0]), .mem_busy(busy[0]));

  sdram_chan_arbiter #(.N(N), .FIXED_PRIO(1), .WD_CYCLES(31)) dut_fp (
    .clk(clk), .reset(reset), .cli_req(req_fp), .cli_we(we), .cli_be(be),
    .cli_addr(addr), .cli_din(din), .cli_ack(ack[1]), .cli_dout(cdout[1]),
    .mem_addr(maddr[1]), .mem_rd(mrd[1]), .mem_wrl(mwrl[1]), .mem_wrh(mwrh[1]),
    .mem_din(mdin[1]), .mem_dout(mdout[1]), .mem_busy(busy[1]));

  // Controller model: a rising strobe starts a lat-cycle busy window;
  // instance 0 can be told to ignore one specific strobe edge.
  for (genvar k = 0; k < 2; k++) begin : g_mem
    logic        prev = 1'b0;
    logic        bz   = 1'b0;
    logic [15:0] dz   = '0;
    logic [15:0] nxt  = '0;
    int          cnt  = 0;
    int          ec   = 0;
    wire         stb  = mrd[k] | mwrl[k] | mwrh[k];
    assign busy[k]  = bz;
    assign mdout[k] = dz;
    always @(posedge clk) begin
      prev <= stb;
      if (stb && !prev) begin
        ec <= ec + 1;
        if (!(k == 0 && ec == ignore_idx)) begin
          bz  <= 1'b1;
          cnt <= lat;
          nxt <= maddr[k][15:0] ^ 16'h9DAA;
        end
      end else if (bz) begin
        if (cnt > 1) cnt <= cnt - 1;
        else begin
          bz <= 1'b0;
          dz <= nxt;
        end
      end
    end
  end

  task automatic set_cli(input int c, input logic w, input logic [1:0] b,
                         input logic [23:0] a, input logic [15:0] d);
    we[c]          = w;
    be[2*c +: 2]   = b;
    addr[24*c +: 24] = a;
    din[16*c +: 16]  = d;
  endtask

  // Bounded wait for an ack on one instance; idx=-1 on timeout, -2 if not one-hot.
  task automatic wait_ack(input int inst, input int maxc, output int idx);
    int cyc;
    idx = -1;
    cyc = 0;
    while (cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (ack[inst] != '0) begin
        idx = -2;
        if ($onehot(ack[inst]))
          for (int b = 0; b < N; b++) if (ack[inst][b]) idx = b;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (ack[0] !== '0 || ack[1] !== '0) begin
      fails++; $display("FAIL reset_ack: got %b/%b want 0000", ack[0], ack[1]);
    end
    tests++;
    if ({mrd[0], mwrl[0], mwrh[0], mrd[1], mwrl[1], mwrh[1]} !== 6'b0) begin
      fails++; $display("FAIL reset_strobes: got %b%b%b want 000", mrd[0], mwrl[0], mwrh[0]);
    end
    tests++;
    if (maddr[0] !== 24'h0 || mdin[0] !== 16'h0 || cdout[0] !== 16'h0) begin
      fails++; $display("FAIL reset_data: addr %h din %h dout %h want 0", maddr[0], mdin[0], cdout[0]);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    int idx;
    set_cli(2, 1'b0, 2'b00, 24'h012345, 16'h0);
    req[2] = 1'b1;
    @(negedge clk);
    tests++;
    if (mrd[0] !== 1'b1 || maddr[0] !== 24'h012345) begin
      fails++; $display("FAIL read_issue: rd %b addr %h want 1 012345", mrd[0], maddr[0]);
    end
    wait_ack(0, 40, idx);
    req[2] = 1'b0;
    tests++;
    if (idx != 2) begin fails++; $display("FAIL read_ack: got idx %0d want 2", idx); end
    tests++;
    if (cdout[0] !== 16'hBEEF) begin fails++; $display("FAIL read_dout: got %h want beef", cdout[0]); end
    tests++;
    if (mrd[0] !== 1'b0) begin fails++; $display("FAIL read_drop: rd %b in ack cycle want 0", mrd[0]); end
    @(negedge clk);
    tests++;
    if (ack[0] !== '0) begin fails++; $display("FAIL read_ack_width: got %b want 0000", ack[0]); end
  endtask

  task automatic test_byte_write();
    int idx;
    set_cli(0, 1'b1, 2'b10, 24'h000100, 16'hA55A);
    req[0] = 1'b1;
    @(negedge clk);
    tests++;
    if ({mrd[0], mwrl[0], mwrh[0]} !== 3'b001 || mdin[0] !== 16'hA55A) begin
      fails++; $display("FAIL write_strobe: rd/wrl/wrh %b%b%b din %h want 001 a55a",
                        mrd[0], mwrl[0], mwrh[0], mdin[0]);
    end
    wait_ack(0, 40, idx);
    req[0] = 1'b0;
    tests++;
    if (idx != 0) begin fails++; $display("FAIL write_ack: got idx %0d want 0", idx); end
    tests++;
    if (cdout[0] !== 16'hBEEF) begin fails++; $display("FAIL write_dout_kept: got %h want beef", cdout[0]); end
    @(negedge clk);
    // Empty write: ack in the cycle after the grant, no strobe at all.
    set_cli(0, 1'b1, 2'b00, 24'h000200, 16'h1234);
    req[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (ack[0] !== 4'b0001 || {mrd[0], mwrl[0], mwrh[0]} !== 3'b000) begin
      fails++; $display("FAIL be00_ack: ack %b strobes %b%b%b want 0001 000",
                        ack[0], mrd[0], mwrl[0], mwrh[0]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (ack[0] !== '0 || {mrd[0], mwrl[0], mwrh[0]} !== 3'b000) begin
      fails++; $display("FAIL be00_after: ack %b strobes %b%b%b want 0000 000",
                        ack[0], mrd[0], mwrl[0], mwrh[0]);
    end
  endtask

  task automatic test_round_robin();
    int idx;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int c = 0; c < N; c++) set_cli(c, 1'b0, 2'b00, 24'(24'h000400 + c), 16'h0);
    reset = 1'b0;
    req = '1;
    for (int g = 0; g < 8; g++) begin
      wait_ack(0, 50, idx);
      if (g == 7) req = '0;
      tests++;
      if (idx != (g % N)) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", g, idx, g % N); end
    end
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int idx;
    req_fp = '1;
    for (int g = 0; g < 3; g++) begin
      wait_ack(1, 50, idx);
      if (g == 2) req_fp[0] = 1'b0;
      tests++;
      if (idx != 0) begin fails++; $display("FAIL fp_grant[%0d]: got %0d want 0", g, idx); end
    end
    wait_ack(1, 50, idx);
    req_fp = '0;
    tests++;
    if (idx != 1) begin fails++; $display("FAIL fp_next: got %0d want 1", idx); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [3];
    int nack, rises, cyc, bad;
    logic prev;
    nack = 0; rises = 0; cyc = 0; bad = 0; prev = 1'b0;
    set_cli(1, 1'b0, 2'b00, 24'h000010, 16'h0);
    req[1] = 1'b1;
    while (nack < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mrd[0] && !prev) rises++;
      prev = mrd[0];
      if (ack[0] != '0) begin
        if (ack[0] !== 4'b0010) bad++;
        got[nack] = cdout[0];
        nack++;
        if (nack == 3) req[1] = 1'b0;
        else addr[24 +: 24] = 24'(24'h000010 * (nack + 1));
      end
    end
    tests++;
    if (nack != 3 || bad != 0) begin fails++; $display("FAIL b2b_acks: got %0d acks (%0d wrong) want 3", nack, bad); end
    tests++;
    if (rises != 3) begin fails++; $display("FAIL b2b_edges: got %0d rd rises want 3", rises); end
    tests++;
    if (got[0] !== 16'h9DBA || got[1] !== 16'h9D8A || got[2] !== 16'h9D9A) begin
      fails++; $display("FAIL b2b_dout: got %h %h %h want 9dba 9d8a 9d9a", got[0], got[1], got[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int hi, lo, idx;
    ignore_idx = g_mem[0].ec;
    set_cli(3, 1'b0, 2'b00, 24'h000040, 16'h0);
    req[3] = 1'b1;
    @(negedge clk);
    hi = 0;
    while (mrd[0] === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    lo = 0;
    while (mrd[0] === 1'b0 && lo < 100) begin lo++; @(negedge clk); end
    tests++;
    if (hi != 31 || lo != 1) begin fails++; $display("FAIL wd_gap: high %0d low %0d want 31 1", hi, lo); end
    wait_ack(0, 40, idx);
    req[3] = 1'b0;
    tests++;
    if (idx != 3 || cdout[0] !== 16'h9DEA) begin
      fails++; $display("FAIL wd_retry: idx %0d dout %h want 3 9dea", idx, cdout[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int cyc, bad, idx;
    lat = 20;
    set_cli(2, 1'b0, 2'b00, 24'h000050, 16'h0);
    req[2] = 1'b1;
    cyc = 0;
    while (busy[0] !== 1'b1 && cyc < 20) begin cyc++; @(negedge clk); end
    tests++;
    if (busy[0] !== 1'b1) begin fails++; $display("FAIL rmw_busy: busy %b want 1", busy[0]); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lat = 5;
    @(negedge clk);
    tests++;
    if (mrd[0] !== 1'b0 || ack[0] !== '0) begin
      fails++; $display("FAIL rmw_drop: rd %b ack %b want 0 0000", mrd[0], ack[0]);
    end
    reset = 1'b0;
    bad = 0; cyc = 0;
    while (busy[0] === 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mrd[0] !== 1'b0 || ack[0] !== '0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rmw_sync: %0d cycles with strobe/ack while busy want 0", bad); end
    wait_ack(0, 40, idx);
    req[2] = 1'b0;
    tests++;
    if (idx != 2 || cdout[0] !== 16'h9DFA) begin
      fails++; $display("FAIL rmw_regrant: idx %0d dout %h want 2 9dfa", idx, cdout[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_fp = '0; we = '0; be = '0; addr = '0; din = '0;
    test_reset();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end
endmodule
